// File: rtl/multdiv_32.sv
// Multicycle signed multiply/divide beside the execute-stage ALU.
// Radix-2 Booth multiply or restoring magnitude divide, one bit per clock, then a FIX cycle.
module multdiv_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  // hi/lo hold the Booth product during multiply and remainder/quotient during divide
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH:0]   opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             dexc_q, dexc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             mul_start, div_start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   booth_sum, div_shifted, div_trial;

  assign mul_start = ctrl_MULT & ~ctrl_DIV;
  assign div_start = ctrl_DIV & ~ctrl_MULT;
  assign mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_comb begin
    booth_sum = hi_q;
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + opnd_q;
      2'b10:   booth_sum = hi_q - opnd_q;
      default: booth_sum = hi_q;
    endcase
  end

  assign div_shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign div_trial   = div_shifted - opnd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dexc_d   = dexc_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      MUL: begin
        hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      DIV: begin
        if (!div_trial[WIDTH]) begin
          hi_d = div_trial;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shifted;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
        if (!is_div_q) begin
          result_d = lo_q;
          exc_d    = (hi_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}});
        end else if (dexc_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else begin
          result_d = neg_q ? -lo_q : lo_q;
          exc_d    = 1'b0;
        end
      end
      default: ;
    endcase

    // A lone start pulse wins over any in-flight work; FIX still reports its result.
    if (mul_start) begin
      state_d  = MUL;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = data_operandB;
      qm1_d    = 1'b0;
      opnd_d   = {data_operandA[WIDTH-1], data_operandA};
      is_div_d = 1'b0;
      neg_d    = 1'b0;
      dexc_d   = 1'b0;
    end else if (div_start) begin
      state_d  = DIV;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = mag_a;
      qm1_d    = 1'b0;
      opnd_d   = {1'b0, mag_b};
      is_div_d = 1'b1;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dexc_d   = (data_operandB == '0) ||
                 ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dexc_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dexc_q   <= dexc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule
